dm_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data memory (dm) between the CPU M-stage data port (m0) and a secondary master (m1, DMA/debug loader).
- Sequences each access as address phase, then write/read phase, then acknowledge.
- Round-robin grant by default.
- Drives the dm's memaddr/dmi/memwrite/dmictr inputs and returns read data and a per-master ack/error.

---
 rtl/dm_arbiter.sv | 147 ++++++++++++++
 tb/tb_dm_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter for the single-port data memory (m0 = CPU, m1 = DMA/debug).
// Round-robin by default; define ARB_FIXED_PRIO_EN to make m0 always win a tie.
module dm_arbiter #(
  parameter logic [31:0] DM_TOP = 32'h0000_3FFF,
  parameter int          CTR_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [CTR_W-1:0] m0_ctr,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [CTR_W-1:0] m1_ctr,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [31:0]      m1_rdata,
  output logic [31:0]      memaddr,
  output logic [31:0]      dmi,
  output logic             memwrite,
  output logic [CTR_W-1:0] dmictr,
  input  logic [31:0]      dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic              r_bad;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [CTR_W-1:0]  r_ctr;
  logic [31:0]       r_m0_rdata;
  logic [31:0]       r_m1_rdata;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              r_m0_err;
  logic              r_m1_err;

  logic              w_any;
  logic              w_gnt_m1;
  logic              w_grant;
  logic              w_data;
  logic              w_rd_ok;
  logic [31:0]       w_addr;

  assign w_any = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
  assign w_gnt_m1 = m1_req & ~m0_req;
`else
  // on a tie, the master that did not own the bus last goes next
  assign w_gnt_m1 = m1_req & (~m0_req | ~r_last_owner);
`endif

  assign w_grant = (r_state == S_IDLE) & w_any;
  assign w_data  = (r_state == S_DATA);
  assign w_rd_ok = w_data & ~r_we & ~r_bad;
  assign w_addr  = w_gnt_m1 ? m1_addr : m0_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_ADDR;
      S_ADDR: w_next = S_DATA;
      S_DATA: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
    endcase
  end

  // memwrite is decoded from state so reset drops it immediately
  always_comb begin
    memaddr  = r_addr;
    dmi      = r_wdata;
    dmictr   = r_ctr;
    memwrite = w_data & r_we & ~r_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ctr   <= '0;
    end else if (w_grant) begin
      r_owner <= w_gnt_m1;
      r_we    <= w_gnt_m1 ? m1_we    : m0_we;
      r_addr  <= w_addr;
      r_wdata <= w_gnt_m1 ? m1_wdata : m0_wdata;
      r_ctr   <= w_gnt_m1 ? m1_ctr   : m0_ctr;
      r_bad   <= (w_addr > DM_TOP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= 1'b1;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
    end else begin
      r_m0_ack <= w_data & ~r_owner;
      r_m1_ack <= w_data & r_owner;
      r_m0_err <= w_data & ~r_owner & r_bad;
      r_m1_err <= w_data & r_owner & r_bad;
      if (w_data) r_last_owner <= r_owner;
      if (w_rd_ok & ~r_owner) r_m0_rdata <= dm_rdata;
      if (w_rd_ok & r_owner)  r_m1_rdata <= dm_rdata;
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_err   = r_m0_err;
  assign m1_err   = r_m1_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a small word-addressed dm model.
// Expected arbitration order follows ARB_FIXED_PRIO_EN when it is defined.
module tb_dm_arbiter;

  localparam logic [2:0] CTR_SW = 3'b000;
  localparam logic [2:0] CTR_LW = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [2:0]  m0_ctr = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m1_ctr = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] memaddr, dmi, dm_rdata;
  logic        memwrite;
  logic [2:0]  dmictr;

  dm_arbiter #(.DM_TOP(32'h0000_3FFF), .CTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ctr(m0_ctr),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ctr(m1_ctr),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .memaddr(memaddr), .dmi(dmi), .memwrite(memwrite),
    .dmictr(dmictr), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        mem_init = 1'b1;

  assign dm_rdata = mem[memaddr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (memwrite) begin
      mem[memaddr[7:2]] <= dmi;
    end
  end

  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [2:0]  wr_ctr = '0;

  always @(negedge clk) begin
    if (memwrite) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= memaddr;
      wr_data <= dmi;
      wr_ctr  <= dmictr;
    end
  end

  typedef struct {
    int          master;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  task automatic reset_dut();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  // waits for any ack; who=-1 on timeout
  task automatic wait_any_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m0_ack || m1_ack) begin
        total++;
        if (m0_ack && m1_ack) begin
          bad++;
          $display("FAIL both_acks: m0_ack=%b m1_ack=%b want one", m0_ack, m1_ack);
        end
        who = m1_ack ? 1 : 0;
        return;
      end
    end
  endtask

  task automatic check_ack(input int who, input int cyc, input int exp_cyc, input string nm);
    exp_t        e;
    logic        err;
    logic [31:0] rd;
    total++;
    if (who < 0 || sb.size() == 0) begin
      bad++;
      $display("FAIL %s_timeout: no ack seen, want ack", nm);
      return;
    end
    e = sb.pop_front();
    if (who !== e.master) begin
      bad++;
      $display("FAIL %s_owner: got m%0d want m%0d", nm, who, e.master);
    end
    total++;
    if (cyc !== exp_cyc) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, cyc, exp_cyc);
    end
    err = who ? m1_err : m0_err;
    rd  = who ? m1_rdata : m0_rdata;
    total++;
    if (err !== e.err) begin
      bad++;
      $display("FAIL %s_err: got %b want %b", nm, err, e.err);
    end
    total++;
    if (rd !== e.rdata) begin
      bad++;
      $display("FAIL %s_rdata: got %h want %h", nm, rd, e.rdata);
    end
  endtask

  task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] ctr,
                           input logic xerr, input logic [31:0] xrd, input string nm);
    exp_t e;
    int   who, cyc;
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_ctr = ctr;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_ctr = ctr;
    end
    e.master = m;
    e.err    = xerr;
    e.rdata  = xrd;
    sb.push_back(e);
    wait_any_ack(who, cyc);
    m0_req = 1'b0;
    m1_req = 1'b0;
    check_ack(who, cyc, 3, nm);
    sb.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if ({memaddr, dmi, memwrite, dmictr} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got %h %h %b %h want zeros", memaddr, dmi, memwrite, dmictr);
    end
    total++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ack: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_single_write();
    int w0;
    w0 = wr_cnt;
    do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, CTR_SW, 1'b0, exp_rd0, "wr");
    total++;
    if (wr_cnt - w0 !== 1) begin
      bad++;
      $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0);
    end
    total++;
    if ({wr_addr, wr_data, wr_ctr} !== {32'h10, 32'hDEAD_BEEF, CTR_SW}) begin
      bad++;
      $display("FAIL wr_bus: got %h %h %h want 10 deadbeef %h", wr_addr, wr_data, wr_ctr, CTR_SW);
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    int   who, cyc, n0, n1, want0, want1;
    int   order[4];
    reset_dut();
`ifdef ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 1};
    want0 = 3;
    want1 = 1;
`else
    order = '{0, 1, 0, 1};
    want0 = 2;
    want1 = 2;
`endif
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      e.master = order[i];
      e.err    = 1'b0;
      e.rdata  = order[i] ? 32'hA000_0002 : 32'hA000_0001;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4; m0_ctr = CTR_LW;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8; m1_ctr = CTR_LW;
    for (int i = 0; i < 4; i++) begin
      wait_any_ack(who, cyc);
      check_ack(who, cyc, (i == 0) ? 3 : 4, "arb");
      if (who < 0) break;
      if (who == 0 && ++n0 == want0) m0_req = 1'b0;
      if (who == 1 && ++n1 == want1) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    sb.delete();
    exp_rd0 = 32'hA000_0001;
    exp_rd1 = 32'hA000_0002;
  endtask

  task automatic test_write_read();
    do_access(1, 1'b1, 32'h20, 32'h1234_5678, CTR_SW, 1'b0, exp_rd1, "m1wr");
    do_access(0, 1'b0, 32'h20, 32'h0, CTR_LW, 1'b0, 32'h1234_5678, "m0rd");
    exp_rd0 = 32'h1234_5678;
    total++;
    if (m1_rdata !== exp_rd1) begin
      bad++;
      $display("FAIL m1_rdata_kept: got %h want %h", m1_rdata, exp_rd1);
    end
  endtask

  task automatic test_out_of_range();
    int w0;
    w0 = wr_cnt;
    do_access(0, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, CTR_SW, 1'b1, exp_rd0, "oor");
    total++;
    if (wr_cnt !== w0) begin
      bad++;
      $display("FAIL oor_nowrite: got %0d writes want 0", wr_cnt - w0);
    end
    do_access(0, 1'b0, 32'h0, 32'h0, CTR_LW, 1'b0, 32'hA000_0000, "oor_rd0");
    exp_rd0 = 32'hA000_0000;
  endtask

  task automatic test_reset_mid_access();
    int   acks;
    logic seen;
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30;
    m1_wdata = 32'h5555_AAAA; m1_ctr = CTR_SW;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (memwrite) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rmid_data: memwrite never rose, want 1");
    end
    rst = 1'b1;
    m1_req = 1'b0;
    #1;
    total++;
    if ({memaddr, dmi, memwrite, dmictr} !== '0) begin
      bad++;
      $display("FAIL rmid_bus: got %h %h %b %h want zeros", memaddr, dmi, memwrite, dmictr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (m1_ack || m0_ack) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL rmid_noack: got %0d acks want 0", acks);
    end
    total++;
    if (mem[12] !== 32'hA000_000C) begin
      bad++;
      $display("FAIL rmid_lost: got %h want a000000c", mem[12]);
    end
    do_access(0, 1'b0, 32'h30, 32'h0, CTR_LW, 1'b0, 32'hA000_000C, "rmid_rd");
  endtask

  initial begin
    mem_init = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    test_reset();
    test_single_write();
    test_arbitration();
    test_write_read();
    test_out_of_range();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
